pio_shadow_out: RTL and testbench
=================================

Name: pio_shadow_out

Overview:
- Parametrised successor to the single-register Avalon-MM output PIO used for colour and status lines.
- Provides CHANNELS output registers of WIDTH bits each, with double buffering:
  - The CPU writes shadow registers.
  - Active registers drive out_port.
  - Shadow is copied to active on the next frame_sync rising edge after a COMMIT. This prevents mid-frame tearing of bar colours and palettes.
- Supports an immediate-update mode and an optional commit-done interrupt.

Parameters:
- WIDTH, 12, bits per channel (1..32)
- CHANNELS, 4, number of output channels (1..8)
- ADDR_W, 4, Avalon address width; CHANNELS+2 <= 2**ADDR_W
- INIT, 0, reset value of every shadow and active channel register (WIDTH bits)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  ADDR_W  Avalon word address
- chipselect  in  1  Avalon select
- write_n  in  1  Avalon write strobe, active low
- writedata  in  32  write data
- readdata  out  32  read data, combinational from address (zero wait states)
- frame_sync  in  1  asynchronous frame strobe (vsync); rising edge is the commit point
- out_port  out  CHANNELS*WIDTH  active registers; channel n occupies bits [n*WIDTH +: WIDTH]
- irq  out  1  level interrupt = irq_flag & IRQ_EN

Behaviour:
- Reset: all of the following are cleared.
  - shadow[n] = active[n] = INIT, so out_port = {CHANNELS{INIT}}.
  - CTRL = 0, pending = 0, irq_flag = 0.
  - Sync flops = 0, so irq = 0.
- Write strobe is wr = chipselect & ~write_n.
- Address map:
  - 0..CHANNELS-1: DATA[n], read/write, writedata[WIDTH-1:0]; upper bits ignored on write, read as 0.
  - CHANNELS: CTRL.
    - bit0 COMMIT: write 1 sets pending; reads back pending.
    - bit1 IMMEDIATE: read/write.
    - bit2 IRQ_EN: read/write.
  - CHANNELS+1: STATUS.
    - bit0 PENDING: read only.
    - bit1 IRQ_FLAG: write 1 to clear.
  - All other addresses read 0; writes to them are ignored.
- DATA write: shadow[n] updates at the next clk edge.
  - If IMMEDIATE = 1, active[n] also updates at that same edge. Pending and the commit path are unaffected.
- frame_sync path:
  - Two-flop synchroniser s1, s2, then a delay flop s3.
  - tick = s2 & ~s3.
  - out_port changes at the 3rd clk rising edge after frame_sync is first sampled high.
  - Minimum frame_sync high and low time: 2 clk periods.
- Commit: on a clk edge with tick & pending, all of the following happen at that edge.
  - active[all] <= shadow[all].
  - pending <= 0.
  - irq_flag <= 1.
- tick with pending = 0: no effect.
- Simultaneous events:
  - COMMIT write in the same cycle as tick: no commit on this tick. Pending becomes 1 and the commit occurs on the next tick.
  - DATA write in the same cycle as a committing tick: active takes the pre-write shadow value. The new value stays in shadow only.
  - IRQ_FLAG W1C in the same cycle as a commit set: set wins, irq_flag stays 1.
  - COMMIT write while pending = 1: no change; a single commit occurs.
- Clearing IMMEDIATE does not alter active contents.
- Reset asserted mid-operation (pending = 1): pending is lost, and active/shadow return to INIT.
- Reset released while frame_sync is high: s2 rises after 2 edges and produces one tick. With pending = 0 this is harmless.

Decomposition:
- Shared package pio_shadow_pkg holds:
  - Address offset functions OFF_CTRL(CHANNELS) and OFF_STATUS(CHANNELS).
  - CTRL bit indices COMMIT=0, IMMEDIATE=1, IRQ_EN=2.
  - STATUS bit indices PENDING=0, IRQ_FLAG=1.
- One sub-module, sync_rise_detect: 2-flop synchroniser plus rising-edge pulse with asynchronous active-low reset. It is reusable for other vsync-gated PIOs.

Test Plan:
- Reset then read: read DATA0..3 (WIDTH=12, CHANNELS=4, INIT=0), CTRL and STATUS -> all reads 0; out_port = 0; irq = 0.
- Shadowed commit:
  - Write DATA0=0xF00, DATA3=0x00F, then CTRL=0x5 (COMMIT, IRQ_EN) -> out_port unchanged and STATUS=0x1.
  - Pulse frame_sync -> 3 clks later out_port[11:0]=0xF00 and out_port[47:36]=0x00F; STATUS=0x2; irq=1.
  - Write STATUS=0x2 -> irq=0.
- Immediate mode: write CTRL=0x2, then DATA1=0xABC -> out_port[23:12]=0xABC at the next edge; frame_sync pulses cause no change and irq stays 0.
- Same-cycle race, with pending=1 and shadow0=0x111:
  - Write DATA0=0x222 in the cycle tick is high -> active0=0x111, shadow0=0x222, pending=0.
  - Second case: COMMIT write coincident with tick -> commit occurs on the following pulse only.
- W1C race: clear IRQ_FLAG in the same cycle as a commit -> STATUS bit1 remains 1.
- Reset mid-pending: set pending, assert reset_n=0 for 1 cycle before the frame_sync pulse -> out_port=INIT, STATUS=0, no commit on the later pulse.

Source files
------------

// File: rtl/pio_shadow_pkg.sv
// Shared register map for the vsync-gated output PIO family.
// Address offsets depend on the channel count. Bit indices are fixed.
package pio_shadow_pkg;

    localparam int CTRL_COMMIT    = 0;
    localparam int CTRL_IMMEDIATE = 1;
    localparam int CTRL_IRQ_EN    = 2;

    localparam int STAT_PENDING   = 0;
    localparam int STAT_IRQ_FLAG  = 1;

    typedef struct packed {
        logic irq_en;
        logic immediate;
    } ctrl_t;

    function automatic int OFF_CTRL(input int channels);
        return channels;
    endfunction

    function automatic int OFF_STATUS(input int channels);
        return channels + 1;
    endfunction

endpackage

// File: rtl/pio_shadow_out_if.sv
// Avalon-MM slave bus for the shadowed output PIO: zero-wait-state reads, strobed writes.
interface pio_shadow_out_if #(
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/sync_rise_detect.sv
// Two-flop synchroniser followed by a delay flop.
// Emits a one-clk pulse on each synchronised rising edge.
module sync_rise_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic rise
);
    // [0],[1] form the synchroniser; [2] is the edge-detect delay.
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[1:0], async_in};
    end

    assign rise = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/pio_shadow_out.sv
// Double-buffered multi-channel output PIO. CPU writes land in shadow registers,
// which are copied to the active outputs on the first frame_sync rise after a COMMIT.
module pio_shadow_out
    import pio_shadow_pkg::*;
#(
    parameter int               WIDTH    = 12,
    parameter int               CHANNELS = 4,
    parameter int               ADDR_W   = 4,
    parameter logic [WIDTH-1:0] INIT     = '0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    pio_shadow_out_if.slave           bus,
    input  logic                      frame_sync,
    output logic [CHANNELS*WIDTH-1:0] out_port,
    output logic                      irq
);
    localparam int A_CTRL = OFF_CTRL(CHANNELS);
    localparam int A_STAT = OFF_STATUS(CHANNELS);

    logic [CHANNELS-1:0][WIDTH-1:0] shadow_q, active_q;
    ctrl_t                          ctrl_q;
    logic                           pending_q, irq_flag_q;
    logic                           wr, wr_ctrl, wr_stat, tick, commit;
    logic [CHANNELS-1:0]            wr_data;
    logic [31:0]                    rdata;
    logic                           unused_wdata;

    assign wr      = bus.chipselect & ~bus.write_n;
    assign wr_ctrl = wr && (bus.address == ADDR_W'(A_CTRL));
    assign wr_stat = wr && (bus.address == ADDR_W'(A_STAT));

    genvar n;
    generate
        for (n = 0; n < CHANNELS; n++) begin : g_dec
            assign wr_data[n] = wr && (bus.address == ADDR_W'(n));
        end
    endgenerate

    sync_rise_detect u_fs_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (frame_sync),
        .rise     (tick)
    );

    // A COMMIT written on the tick cycle sees pending_q=0 and waits for the next tick.
    assign commit = tick & pending_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q   <= {CHANNELS{INIT}};
            active_q   <= {CHANNELS{INIT}};
            ctrl_q     <= '0;
            pending_q  <= 1'b0;
            irq_flag_q <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_data[i]) begin
                    shadow_q[i] <= bus.writedata[WIDTH-1:0];
                    if (ctrl_q.immediate) active_q[i] <= bus.writedata[WIDTH-1:0];
                end
            end
            // Commit overrides any same-cycle immediate write: active takes pre-write shadow.
            if (commit) active_q <= shadow_q;

            if (wr_ctrl) begin
                ctrl_q.irq_en    <= bus.writedata[CTRL_IRQ_EN];
                ctrl_q.immediate <= bus.writedata[CTRL_IMMEDIATE];
            end

            if (commit)                                    pending_q <= 1'b0;
            else if (wr_ctrl && bus.writedata[CTRL_COMMIT]) pending_q <= 1'b1;

            if (commit)                                      irq_flag_q <= 1'b1;
            else if (wr_stat && bus.writedata[STAT_IRQ_FLAG]) irq_flag_q <= 1'b0;
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.address == ADDR_W'(i)) rdata = 32'(shadow_q[i]);
        end
        if (bus.address == ADDR_W'(A_CTRL)) begin
            rdata[CTRL_COMMIT]    = pending_q;
            rdata[CTRL_IMMEDIATE] = ctrl_q.immediate;
            rdata[CTRL_IRQ_EN]    = ctrl_q.irq_en;
        end
        if (bus.address == ADDR_W'(A_STAT)) begin
            rdata[STAT_PENDING]  = pending_q;
            rdata[STAT_IRQ_FLAG] = irq_flag_q;
        end
    end

    assign bus.readdata = rdata;
    assign out_port     = active_q;
    assign irq          = irq_flag_q & ctrl_q.irq_en;
    assign unused_wdata = &{1'b0, bus.writedata};
endmodule

// File: tb/tb_pio_shadow_out.sv
// Directed bench for pio_shadow_out: stimulus pushes expected values, a negedge monitor pops and compares.
module tb_pio_shadow_out;
    localparam int WIDTH = 12, CHANNELS = 4, ADDR_W = 4;

    logic clk = 1'b0, reset_n = 1'b0, frame_sync = 1'b0, irq;
    logic [CHANNELS*WIDTH-1:0] out_port;

    pio_shadow_out_if #(.ADDR_W(ADDR_W)) bus ();

    pio_shadow_out #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .ADDR_W(ADDR_W), .INIT('0)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .frame_sync (frame_sync),
        .out_port   (out_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // kind 0: readdata, 1: out_port, 2: irq
    typedef struct {
        string       name;
        int          kind;
        logic [47:0] val;
    } exp_t;

    exp_t exp_q[$];
    logic mon_vld = 1'b0;
    int   total = 0, bad = 0;

    always @(negedge clk) begin
        if (mon_vld) begin
            exp_t        e;
            logic [47:0] obs;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard: got empty queue want entry");
            end else begin
                e = exp_q.pop_front();
                case (e.kind)
                    0:       obs = 48'(bus.readdata);
                    1:       obs = out_port;
                    default: obs = 48'(irq);
                endcase
                if (obs !== e.val) begin
                    bad++;
                    $display("FAIL %s: got %h want %h", e.name, obs, e.val);
                end
            end
        end
    end

    task automatic idle();
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.write_n = 1'b1; mon_vld = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
        mon_vld = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] v, input string nm);
        @(posedge clk); #1;
        bus.chipselect = 1'b1; bus.write_n = 1'b1; bus.address = a;
        exp_q.push_back('{nm, 0, 48'(v)});
        mon_vld = 1'b1;
    endtask

    task automatic chk(input int kind, input logic [47:0] v, input string nm);
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
        exp_q.push_back('{nm, kind, v});
        mon_vld = 1'b1;
    endtask

    task automatic fs_set();
        @(posedge clk); #1;
        frame_sync = 1'b1; bus.chipselect = 1'b0; bus.write_n = 1'b1; mon_vld = 1'b0;
    endtask

    task automatic fs_clr();
        @(posedge clk); #1;
        frame_sync = 1'b0; bus.chipselect = 1'b0; bus.write_n = 1'b1; mon_vld = 1'b0;
        repeat (3) idle();
    endtask

    task automatic pulse_fs();
        fs_set();
        repeat (3) idle();
        fs_clr();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // reset state
        for (int i = 0; i < 4; i++) rd(4'(i), 32'h0, "rst_data");
        rd(4'd4, 32'h0, "rst_ctrl");
        rd(4'd5, 32'h0, "rst_status");
        chk(1, 48'h0, "rst_out");
        chk(2, 48'h0, "rst_irq");

        // shadowed commit, upper writedata bits dropped
        wr(4'd0, 32'h1234_5F00);
        wr(4'd3, 32'h0000_000F);
        wr(4'd4, 32'h5);
        rd(4'd0, 32'hF00, "shadow0_rd");
        chk(1, 48'h0, "pre_commit_out");
        rd(4'd5, 32'h1, "pending_set");
        rd(4'd4, 32'h5, "ctrl_rd");
        fs_set();
        idle();
        chk(1, 48'h0, "commit_not_early");
        chk(1, 48'h00F_000_000_F00, "commit_3rd_edge");
        fs_clr();
        rd(4'd5, 32'h2, "status_after_commit");
        chk(2, 48'h1, "irq_set");
        wr(4'd5, 32'h2);
        chk(2, 48'h0, "irq_w1c");
        rd(4'd5, 32'h0, "status_cleared");
        rd(4'd4, 32'h4, "ctrl_after_commit");

        // immediate mode
        wr(4'd4, 32'h2);
        wr(4'd1, 32'hABC);
        chk(1, 48'h00F_000_ABC_F00, "immediate_out");
        pulse_fs();
        chk(1, 48'h00F_000_ABC_F00, "imm_fs_nochange");
        chk(2, 48'h0, "imm_irq_low");
        rd(4'd5, 32'h0, "imm_status");

        // DATA write on the committing tick
        wr(4'd4, 32'h0);
        chk(1, 48'h00F_000_ABC_F00, "clr_imm_keeps_active");
        wr(4'd0, 32'h111);
        wr(4'd4, 32'h1);
        fs_set();
        idle();
        wr(4'd0, 32'h222);
        chk(1, 48'h00F_000_ABC_111, "race_data_active");
        rd(4'd0, 32'h222, "race_data_shadow");
        rd(4'd5, 32'h2, "race_data_status");
        chk(2, 48'h0, "irq_gated_by_en");
        fs_clr();
        wr(4'd5, 32'h2);
        rd(4'd5, 32'h0, "w1c_again");

        // COMMIT write on the tick cycle is deferred
        wr(4'd4, 32'h4);
        fs_set();
        idle();
        wr(4'd4, 32'h5);
        rd(4'd5, 32'h1, "race_commit_pending");
        chk(1, 48'h00F_000_ABC_111, "race_commit_nochange");
        fs_clr();
        pulse_fs();
        chk(1, 48'h00F_000_ABC_222, "deferred_commit");
        rd(4'd5, 32'h2, "deferred_status");
        chk(2, 48'h1, "deferred_irq");

        // W1C against commit set: set wins
        wr(4'd0, 32'h333);
        wr(4'd4, 32'h5);
        wr(4'd4, 32'h5);
        rd(4'd5, 32'h3, "double_commit_status");
        fs_set();
        idle();
        wr(4'd5, 32'h2);
        rd(4'd5, 32'h2, "w1c_race_status");
        chk(2, 48'h1, "w1c_race_irq");
        chk(1, 48'h00F_000_ABC_333, "w1c_race_out");
        fs_clr();
        wr(4'd5, 32'h2);
        rd(4'd5, 32'h0, "w1c_final");

        // unmapped addresses
        wr(4'd7, 32'hFFFF);
        rd(4'd7, 32'h0, "unmapped7");
        rd(4'd6, 32'h0, "unmapped6");

        // reset with commit pending
        wr(4'd2, 32'h555);
        wr(4'd4, 32'h1);
        rd(4'd5, 32'h1, "pre_reset_pending");
        @(posedge clk); #1;
        reset_n = 1'b0; bus.chipselect = 1'b0; bus.write_n = 1'b1; mon_vld = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        chk(1, 48'h0, "reset_out");
        rd(4'd5, 32'h0, "reset_status");
        rd(4'd4, 32'h0, "reset_ctrl");
        rd(4'd2, 32'h0, "reset_shadow2");
        pulse_fs();
        chk(1, 48'h0, "no_commit_after_reset");
        rd(4'd5, 32'h0, "status_after_reset_fs");
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
